// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for mem_port_arbiter: core requester (c_*), DMA requester (d_*)
// and the shared memory macro port (m_*).
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  // The arbiter side: requests and memory read data come in, grants/responses and the memory strobe go out.
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  m_rdata,
    output c_gnt, c_rvalid, c_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output m_rdata,
    input  c_gnt, c_rvalid, c_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency memory port between the core (C) and DMA (D).
// Optional grant/stall performance counters are built when MEM_ARB_PERF_EN is defined.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              busy,
  output logic [1:0]        arb_state,
  output logic [15:0]       perf_c_gnt,
  output logic [15:0]       perf_d_gnt,
  output logic [15:0]       perf_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic       OWNER_C  = 1'b0;
  localparam logic       OWNER_D  = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t        state;
  state_t        state_next;
  logic          owner;
  logic          last_owner;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] resp_data;
  logic [3:0]    cnt;
  logic          grant_c;
  logic          grant_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grants are masked during reset so an access never starts in the cycle it would be discarded.
  always_comb begin
    state_next = state;
    grant_c    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (reset) begin
          if (bus.c_req && (!bus.d_req || last_owner == OWNER_D)) begin
            grant_c = 1'b1;
          end else if (bus.d_req) begin
            grant_d = 1'b1;
          end
          if (grant_c || grant_d) begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner      <= OWNER_C;
      last_owner <= OWNER_D;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= 4'd0;
      resp_data  <= '0;
    end else begin
      if (grant_c || grant_d) begin
        owner      <= grant_d;
        last_owner <= grant_d;
        lat_we     <= grant_d ? bus.d_we    : bus.c_we;
        lat_addr   <= grant_d ? bus.d_addr  : bus.c_addr;
        lat_wdata  <= grant_d ? bus.d_wdata : bus.c_wdata;
      end
      case (state)
        ISSUE: cnt <= CNT_LOAD;
        WAIT: begin
          if (cnt == 4'd0) begin
            resp_data <= lat_we ? '0 : bus.m_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The latched address/data double as the memory bus, so they hold their last value outside ISSUE.
  assign bus.m_en    = (state == ISSUE);
  assign bus.m_we    = (state == ISSUE) && lat_we;
  assign bus.m_addr  = lat_addr;
  assign bus.m_wdata = lat_wdata;

  assign bus.c_gnt    = grant_c;
  assign bus.d_gnt    = grant_d;
  assign bus.c_rvalid = (state == RESP) && (owner == OWNER_C);
  assign bus.d_rvalid = (state == RESP) && (owner == OWNER_D);
  assign bus.c_rdata  = bus.c_rvalid ? resp_data : '0;
  assign bus.d_rdata  = bus.d_rvalid ? resp_data : '0;

  assign busy      = (state != IDLE);
  assign arb_state = state;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] cnt_c_gnt;
  logic [15:0] cnt_d_gnt;
  logic [15:0] cnt_stall;

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_c_gnt <= 16'd0;
      cnt_d_gnt <= 16'd0;
      cnt_stall <= 16'd0;
    end else begin
      if (grant_c && cnt_c_gnt != 16'hFFFF) cnt_c_gnt <= cnt_c_gnt + 16'd1;
      if (grant_d && cnt_d_gnt != 16'hFFFF) cnt_d_gnt <= cnt_d_gnt + 16'd1;
      if ((bus.c_req || bus.d_req) && !grant_c && !grant_d && cnt_stall != 16'hFFFF) begin
        cnt_stall <= cnt_stall + 16'd1;
      end
    end
  end

  assign perf_c_gnt = cnt_c_gnt;
  assign perf_d_gnt = cnt_d_gnt;
  assign perf_stall = cnt_stall;
`else
  assign perf_c_gnt = 16'd0;
  assign perf_d_gnt = 16'd0;
  assign perf_stall = 16'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter: two instances (MEM_LATENCY 1 and 4), each with its
// own memory, checked every cycle against a transaction-level timing model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset    [2];
  logic          c_req    [2];
  logic          c_we     [2];
  logic [AW-1:0] c_addr   [2];
  logic [DW-1:0] c_wdata  [2];
  logic          d_req    [2];
  logic          d_we     [2];
  logic [AW-1:0] d_addr   [2];
  logic [DW-1:0] d_wdata  [2];
  logic          c_gnt    [2];
  logic          c_rvalid [2];
  logic [DW-1:0] c_rdata  [2];
  logic          d_gnt    [2];
  logic          d_rvalid [2];
  logic [DW-1:0] d_rdata  [2];
  logic          m_en     [2];
  logic          m_we     [2];
  logic [AW-1:0] m_addr   [2];
  logic [DW-1:0] m_wdata  [2];
  logic          busy     [2];
  logic [1:0]    arb_st   [2];
  logic [15:0]   perf_c   [2];
  logic [15:0]   perf_d   [2];
  logic [15:0]   perf_s   [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int cur_k  = 0;

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 16) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 ^ (a * 32'h0001_0203);
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 1 : 4;
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    logic [DW-1:0] mem     [64];
    logic [63:0]   written = '0;
    logic [15:0]   pipe_v  = '0;
    logic [DW-1:0] pipe_d  [16];
    wire  [5:0]    ma      = bus.m_addr[5:0];

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset[k]),
      .bus        (bus.slave),
      .busy       (busy[k]),
      .arb_state  (arb_st[k]),
      .perf_c_gnt (perf_c[k]),
      .perf_d_gnt (perf_d[k]),
      .perf_stall (perf_s[k])
    );

    assign bus.c_req   = c_req[k];
    assign bus.c_we    = c_we[k];
    assign bus.c_addr  = c_addr[k];
    assign bus.c_wdata = c_wdata[k];
    assign bus.d_req   = d_req[k];
    assign bus.d_we    = d_we[k];
    assign bus.d_addr  = d_addr[k];
    assign bus.d_wdata = d_wdata[k];
    assign c_gnt[k]    = bus.c_gnt;
    assign c_rvalid[k] = bus.c_rvalid;
    assign c_rdata[k]  = bus.c_rdata;
    assign d_gnt[k]    = bus.d_gnt;
    assign d_rvalid[k] = bus.d_rvalid;
    assign d_rdata[k]  = bus.d_rdata;
    assign m_en[k]     = bus.m_en;
    assign m_we[k]     = bus.m_we;
    assign m_addr[k]   = bus.m_addr;
    assign m_wdata[k]  = bus.m_wdata;

    // Read data is only meaningful in the single cycle LAT after m_en; otherwise a poison value.
    assign bus.m_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hBADC_0FFE;

    always @(posedge clk) begin
      pipe_v    <= {pipe_v[14:0], bus.m_en & ~bus.m_we};
      pipe_d[0] <= written[ma] ? mem[ma] : init_word(int'(ma));
      for (int i = 1; i < 16; i++) pipe_d[i] <= pipe_d[i-1];
      if (bus.m_en && bus.m_we) begin
        mem[ma]     <= bus.m_wdata;
        written[ma] <= 1'b1;
      end
    end
  end

  // Reference model state: the last grant and its cycle determine everything seen until the port is free.
  bit            act      [2];
  int            gcyc     [2];
  bit            gown     [2];
  bit            gwe      [2];
  logic [DW-1:0] gdata    [2];
  logic [AW-1:0] eaddr    [2];
  logic [DW-1:0] ewdata   [2];
  bit            last_own [2];
  int            pc       [2];
  int            pd       [2];
  int            ps       [2];
  bit            seen_c   [2];
  bit            seen_d   [2];
  logic [DW-1:0] rmem     [2][64];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %0h expected %0h", tag, cur_k, cyc, got, exp);
    end
  endtask

  task automatic nextReq(input bit seen, inout logic req, inout logic we,
                         inout logic [AW-1:0] addr, inout logic [DW-1:0] wdata);
    if (cyc < 3) begin
      req = 1'b0;
    end else if (!req || seen) begin
      req   = (cyc < 60) ? 1'b1 : ($urandom_range(0, 9) < 6);
      we    = ($urandom_range(0, 2) == 0);
      addr  = AW'($urandom_range(0, 31));
      wdata = $urandom;
    end else if (cyc >= 60 && $urandom_range(0, 19) == 0) begin
      req = 1'b0;
    end
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < 2; k++) begin
      reset[k] = (cyc < 3) ? 1'b0 : !(cyc >= 60 && $urandom_range(0, 79) == 0);
      nextReq(seen_c[k], c_req[k], c_we[k], c_addr[k], c_wdata[k]);
      nextReq(seen_d[k], d_req[k], d_we[k], d_addr[k], d_wdata[k]);
    end
  endtask

  task automatic stepModel(input int k);
    int            lat;
    int            d;
    int            es;
    bit            gc;
    bit            gd;
    bit            rv;
    bit            ren;
    logic [AW-1:0] ra;
    logic [DW-1:0] rw;
    bit            rwe;
    lat   = (k == 0) ? 1 : 4;
    cur_k = k;
    if (act[k] && (cyc - gcyc[k]) >= lat + 3) act[k] = 1'b0;
    d   = cyc - gcyc[k];
    es  = !act[k] ? 0 : (d == 1) ? 1 : (d <= lat + 1) ? 2 : 3;
    gc  = 1'b0;
    gd  = 1'b0;
    if (!act[k] && reset[k]) begin
      if (c_req[k] && (!d_req[k] || last_own[k])) gc = 1'b1;
      else if (d_req[k]) gd = 1'b1;
    end
    rv  = act[k] && (d == lat + 2);
    ren = act[k] && (d == 1);

    checkOutput("c_gnt", 64'(c_gnt[k]), 64'(gc));
    checkOutput("d_gnt", 64'(d_gnt[k]), 64'(gd));
    checkOutput("c_rvalid", 64'(c_rvalid[k]), 64'(rv && !gown[k]));
    checkOutput("d_rvalid", 64'(d_rvalid[k]), 64'(rv && gown[k]));
    checkOutput("c_rdata", 64'(c_rdata[k]), 64'((rv && !gown[k]) ? gdata[k] : '0));
    checkOutput("d_rdata", 64'(d_rdata[k]), 64'((rv && gown[k]) ? gdata[k] : '0));
    checkOutput("m_en", 64'(m_en[k]), 64'(ren));
    checkOutput("m_we", 64'(m_we[k]), 64'(ren && gwe[k]));
    checkOutput("m_addr", 64'(m_addr[k]), 64'(eaddr[k]));
    checkOutput("m_wdata", 64'(m_wdata[k]), 64'(ewdata[k]));
    checkOutput("busy", 64'(busy[k]), 64'(es != 0));
    checkOutput("arb_state", 64'(arb_st[k]), 64'(es));
`ifdef MEM_ARB_PERF_EN
    checkOutput("perf_c_gnt", 64'(perf_c[k]), 64'(pc[k]));
    checkOutput("perf_d_gnt", 64'(perf_d[k]), 64'(pd[k]));
    checkOutput("perf_stall", 64'(perf_s[k]), 64'(ps[k]));
`else
    checkOutput("perf_c_gnt", 64'(perf_c[k]), 64'(0));
    checkOutput("perf_d_gnt", 64'(perf_d[k]), 64'(0));
    checkOutput("perf_stall", 64'(perf_s[k]), 64'(0));
`endif

    seen_c[k] = (c_gnt[k] === 1'b1);
    seen_d[k] = (d_gnt[k] === 1'b1);

    if (!reset[k]) begin
      act[k]      = 1'b0;
      last_own[k] = 1'b1;
      eaddr[k]    = '0;
      ewdata[k]   = '0;
      pc[k]       = 0;
      pd[k]       = 0;
      ps[k]       = 0;
    end else begin
      if (gc && pc[k] < 65535) pc[k]++;
      if (gd && pd[k] < 65535) pd[k]++;
      if ((c_req[k] || d_req[k]) && !gc && !gd && ps[k] < 65535) ps[k]++;
      if (gc || gd) begin
        ra          = gc ? c_addr[k]  : d_addr[k];
        rw          = gc ? c_wdata[k] : d_wdata[k];
        rwe         = gc ? c_we[k]    : d_we[k];
        act[k]      = 1'b1;
        gcyc[k]     = cyc;
        gown[k]     = gd;
        last_own[k] = gd;
        gwe[k]      = rwe;
        eaddr[k]    = ra;
        ewdata[k]   = rw;
        gdata[k]    = rwe ? '0 : rmem[k][ra[5:0]];
        if (rwe) rmem[k][ra[5:0]] = rw;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k]    = 1'b0;
      c_req[k]    = 1'b0;
      c_we[k]     = 1'b0;
      c_addr[k]   = '0;
      c_wdata[k]  = '0;
      d_req[k]    = 1'b0;
      d_we[k]     = 1'b0;
      d_addr[k]   = '0;
      d_wdata[k]  = '0;
      act[k]      = 1'b0;
      gcyc[k]     = 0;
      gown[k]     = 1'b0;
      gwe[k]      = 1'b0;
      gdata[k]    = '0;
      eaddr[k]    = '0;
      ewdata[k]   = '0;
      last_own[k] = 1'b1;
      pc[k]       = 0;
      pd[k]       = 0;
      ps[k]       = 0;
      seen_c[k]   = 1'b0;
      seen_d[k]   = 1'b0;
      for (int i = 0; i < 64; i++) rmem[k][i] = init_word(i);
    end
    $display("[TB] start: %0d cycles, latencies 1 and 4", NCYC);
    while (cyc < NCYC) begin
      @(posedge clk);
      #1;
      applyStimulus();
      @(negedge clk);
      for (int k = 0; k < 2; k++) stepModel(k);
      cyc++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
